// File: rtl/hilo_md_unit.sv
// hilo_md_unit: multi-cycle multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use a restoring divider. Both run one
// iteration per clock, and signs are fixed up in a final DONE cycle.
// The unit also serves MFHI/MFLO and MTHI/MTLO directly from IDLE.
//
// Issue handshake: an instruction is offered when md_i_ce=1 with an RTYPE
// opcode. It is taken on a rising edge only when md_o_stall=0, except for a
// MULT*/DIV* issued in IDLE, which is taken on that edge while md_o_stall is
// already high. Upstream must hold the issuing instruction while md_o_stall=1.
// Instructions offered while BUSY/DONE are dropped. md_o_done pulses for one
// cycle after HI/LO have been written.
module hilo_md_unit #(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 6
) (
    input  logic              md_clk,
    input  logic              md_rst,
    input  logic              md_i_ce,
    input  logic              md_i_flush,
    input  logic [5:0]        md_i_alu_op,
    input  logic [5:0]        md_i_alu_funct,
    input  logic [DWIDTH-1:0] md_i_data_rs,
    input  logic [DWIDTH-1:0] md_i_data_rt,
    output logic              md_o_stall,
    output logic              md_o_done,
    output logic [DWIDTH-1:0] md_o_value,
    output logic              md_o_valid,
    output logic [DWIDTH-1:0] md_o_hi,
    output logic [DWIDTH-1:0] md_o_lo
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] F_MFHI   = 6'h10;
    localparam logic [5:0] F_MTHI   = 6'h11;
    localparam logic [5:0] F_MFLO   = 6'h12;
    localparam logic [5:0] F_MTLO   = 6'h13;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_MULTU  = 6'h19;
    localparam logic [5:0] F_DIV    = 6'h1A;
    localparam logic [5:0] F_DIVU   = 6'h1B;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DWIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    // Upper half: running product high / partial remainder.
    // Lower half: multiplier bits still to consume / quotient being built.
    logic [2*DWIDTH-1:0]     work_q;
    logic [DWIDTH-1:0]       b_mag_q;
    logic                    op_div_q;
    logic                    neg_main_q;   // negate product or quotient
    logic                    neg_rem_q;    // negate remainder (dividend sign)
    logic                    div_zero_q;
    logic [DWIDTH-1:0]       hi_q;
    logic [DWIDTH-1:0]       lo_q;
    logic                    done_q;

    // Instruction decode
    logic rtype;
    logic dec_mul, dec_div, dec_start, dec_signed;
    logic dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;

    assign rtype      = md_i_ce && (md_i_alu_op == OP_RTYPE);
    assign dec_mul    = rtype && ((md_i_alu_funct == F_MULT) || (md_i_alu_funct == F_MULTU));
    assign dec_div    = rtype && ((md_i_alu_funct == F_DIV)  || (md_i_alu_funct == F_DIVU));
    assign dec_start  = dec_mul || dec_div;
    assign dec_signed = (md_i_alu_funct == F_MULT) || (md_i_alu_funct == F_DIV);
    assign dec_mfhi   = rtype && (md_i_alu_funct == F_MFHI);
    assign dec_mflo   = rtype && (md_i_alu_funct == F_MFLO);
    assign dec_mthi   = rtype && (md_i_alu_funct == F_MTHI);
    assign dec_mtlo   = rtype && (md_i_alu_funct == F_MTLO);

    // Operand magnitudes and sign flags captured at start
    logic              a_neg, b_neg;
    logic [DWIDTH-1:0] a_mag, b_mag;

    assign a_neg = dec_signed && md_i_data_rs[DWIDTH-1];
    assign b_neg = dec_signed && md_i_data_rt[DWIDTH-1];
    assign a_mag = a_neg ? (~md_i_data_rs + 1'b1) : md_i_data_rs;
    assign b_mag = b_neg ? (~md_i_data_rt + 1'b1) : md_i_data_rt;

    // One shift-add multiply step: add B into the high half when the current
    // multiplier LSB is set, then shift the whole pair right by one.
    logic [DWIDTH:0]     mul_sum;
    logic [2*DWIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, work_q[2*DWIDTH-1:DWIDTH]}
                    + {1'b0, (work_q[0] ? b_mag_q : {DWIDTH{1'b0}})};
    assign mul_next = {mul_sum, work_q[DWIDTH-1:1]};

    // One restoring divide step: shift the next dividend bit into the
    // remainder and keep the subtraction only if it did not borrow.
    logic [DWIDTH:0]     div_trial;
    logic [2*DWIDTH-1:0] div_next;

    assign div_trial = work_q[2*DWIDTH-1:DWIDTH-1] - {1'b0, b_mag_q};
    assign div_next  = div_trial[DWIDTH]
                     ? {work_q[2*DWIDTH-2:0], 1'b0}
                     : {div_trial[DWIDTH-1:0], work_q[DWIDTH-2:0], 1'b1};

    // Sign correction applied in DONE
    logic [2*DWIDTH-1:0] prod_fix;
    logic [DWIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = neg_main_q ? (~work_q + 1'b1) : work_q;
    assign quo_fix  = div_zero_q ? {DWIDTH{1'b1}}
                    : (neg_main_q ? (~work_q[DWIDTH-1:0] + 1'b1) : work_q[DWIDTH-1:0]);
    assign rem_fix  = neg_rem_q ? (~work_q[2*DWIDTH-1:DWIDTH] + 1'b1)
                                : work_q[2*DWIDTH-1:DWIDTH];

    // Sequencer, HI/LO registers and the done pulse
    always_ff @(posedge md_clk or posedge md_rst) begin
        if (md_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            b_mag_q    <= '0;
            op_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (md_i_flush) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (dec_start) begin
                            work_q     <= {{DWIDTH{1'b0}}, a_mag};
                            b_mag_q    <= b_mag;
                            op_div_q   <= dec_div;
                            neg_main_q <= a_neg ^ b_neg;
                            neg_rem_q  <= a_neg;
                            div_zero_q <= dec_div && (md_i_data_rt == '0);
                            cnt_q      <= '0;
                            state_q    <= ST_BUSY;
                        end else if (dec_mthi) begin
                            hi_q <= md_i_data_rs;
                        end else if (dec_mtlo) begin
                            lo_q <= md_i_data_rs;
                        end
                    end
                    ST_BUSY: begin
                        work_q <= op_div_q ? div_next : mul_next;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (op_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*DWIDTH-1:DWIDTH];
                            lo_q <= prod_fix[DWIDTH-1:0];
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Stall, move-from read port and register views
    always_comb begin
        md_o_stall = ((state_q == ST_IDLE) && dec_start)
                   || (state_q == ST_BUSY) || (state_q == ST_DONE);
        md_o_valid = 1'b0;
        md_o_value = '0;
        if (state_q == ST_IDLE) begin
            if (dec_mfhi) begin
                md_o_valid = 1'b1;
                md_o_value = hi_q;
            end else if (dec_mflo) begin
                md_o_valid = 1'b1;
                md_o_value = lo_q;
            end
        end
    end

    assign md_o_done = done_q;
    assign md_o_hi   = hi_q;
    assign md_o_lo   = lo_q;

endmodule

// File: tb/tb_hilo_md_unit.sv
// tb_hilo_md_unit: directed vector table for MULT*/DIV* plus hand-written
// sequences for move ops, ops issued while busy, back-to-back issue, flush
// and asynchronous reset.
module tb_hilo_md_unit;

  localparam int W = 32;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam int LAT = W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         ce, flush;
  logic [5:0]   op, funct;
  logic [W-1:0] rs, rt;
  logic         stall, done, valid;
  logic [W-1:0] value, hi, lo;

  hilo_md_unit #(.DWIDTH(W), .CNT_WIDTH(6)) dut (
    .md_clk         (clk),
    .md_rst         (rst),
    .md_i_ce        (ce),
    .md_i_flush     (flush),
    .md_i_alu_op    (op),
    .md_i_alu_funct (funct),
    .md_i_data_rs   (rs),
    .md_i_data_rt   (rt),
    .md_o_stall     (stall),
    .md_o_done      (done),
    .md_o_value     (value),
    .md_o_valid     (valid),
    .md_o_hi        (hi),
    .md_o_lo        (lo)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic [5:0]   funct;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  // ---------------- driver tasks ----------------
  // Issue a MULT*/DIV*; hold it for one cycle only (the unit latches it), then
  // count stall cycles until the unit returns to IDLE. Returns at #1 after the
  // negedge of the first non-stalled cycle (the done-pulse cycle).
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit same_cycle, output int cyc, output int early_done,
                        output logic done_at_end);
    if (!same_cycle) @(negedge clk);
    ce = 1'b1; op = 6'h00; funct = f; rs = a; rt = b;
    #1;
    cyc = 0;
    early_done = 0;
    while (stall && cyc < 100) begin
      if (cyc > 0 && done) early_done++;
      cyc++;
      @(negedge clk);
      ce = 1'b0;
      #1;
    end
    done_at_end = done;
  endtask

  task automatic mf_check(input logic [5:0] f, input logic [W-1:0] exp, input string name);
    @(negedge clk);
    ce = 1'b1; op = 6'h00; funct = f;
    #1;
    check({name, " value"}, 64'(value), 64'(exp));
    check({name, " valid"}, 64'(valid), 64'd1);
    check({name, " stall"}, 64'(stall), 64'd0);
    check({name, " done_low"}, 64'(done), 64'd0);
    ce = 1'b0;
  endtask

  task automatic mt_write(input logic [5:0] f, input logic [W-1:0] v);
    @(negedge clk);
    ce = 1'b1; op = 6'h00; funct = f; rs = v;
    #1;
    check("mt stall", 64'(stall), 64'd0);
    @(negedge clk);
    ce = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int   cyc, early, n;
  logic d_end;

  initial begin
    vecs[0]  = '{"mult 5*4",        F_MULT,  32'd5,        32'd4,        32'h0000_0000, 32'h0000_0014};
    vecs[1]  = '{"mult -3*7",       F_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{"multu ffff*2",    F_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
    vecs[3]  = '{"div -7/2",        F_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{"divu 7/2",        F_DIVU,  32'd7,        32'd2,        32'h0000_0001, 32'h0000_0003};
    vecs[5]  = '{"div min/-1",      F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{"divu 7/0",        F_DIVU,  32'd7,        32'd0,        32'h0000_0007, 32'hFFFF_FFFF};
    vecs[7]  = '{"div -7/0",        F_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8]  = '{"mult -4*-5",      F_MULT,  32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0014};
    vecs[9]  = '{"div 7/-2",        F_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{"multu max*max",   F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[11] = '{"divu max/16",     F_DIVU,  32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF};
    vecs[12] = '{"mult min*min",    F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    rst = 1'b1; ce = 1'b0; flush = 1'b0; op = 6'h00; funct = 6'h00; rs = '0; rt = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset valid", 64'(valid), 64'd0);
    check("reset value", 64'(value), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ce=0 or non-RTYPE opcode must not start anything
    @(negedge clk);
    ce = 1'b0; funct = F_MULT; rs = 32'd5; rt = 32'd4;
    #1 check("ce0 no stall", 64'(stall), 64'd0);
    ce = 1'b1; op = 6'h08;
    #1 check("non-rtype no stall", 64'(stall), 64'd0);
    @(negedge clk);
    ce = 1'b0; op = 6'h00;
    #1 check("still idle", 64'(stall), 64'd0);

    // Table-driven MULT*/DIV* vectors
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].funct, vecs[i].rs, vecs[i].rt, 1'b0, cyc, early, d_end);
      check({vecs[i].name, " stall_cycles"}, 64'(cyc), 64'(LAT));
      check({vecs[i].name, " no_early_done"}, 64'(early), 64'd0);
      check({vecs[i].name, " done"}, 64'(d_end), 64'd1);
      check({vecs[i].name, " hi"}, 64'(hi), 64'(vecs[i].exp_hi));
      check({vecs[i].name, " lo"}, 64'(lo), 64'(vecs[i].exp_lo));
      mf_check(F_MFLO, vecs[i].exp_lo, {vecs[i].name, " mflo"});
      mf_check(F_MFHI, vecs[i].exp_hi, {vecs[i].name, " mfhi"});
    end

    // MTHI then MFHI
    mt_write(F_MTHI, 32'h0000_1234);
    mf_check(F_MFHI, 32'h0000_1234, "mthi->mfhi");

    // MTLO and MFHI issued while BUSY are ignored
    @(negedge clk);
    ce = 1'b1; op = 6'h00; funct = F_MULT; rs = 32'd5; rt = 32'd4;
    @(negedge clk);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    ce = 1'b1; funct = F_MTLO; rs = 32'h0000_DEAD;
    #1;
    check("busy mtlo stall", 64'(stall), 64'd1);
    check("busy mtlo valid", 64'(valid), 64'd0);
    funct = F_MFHI;
    #1;
    check("busy mfhi valid", 64'(valid), 64'd0);
    check("busy mfhi value", 64'(value), 64'd0);
    @(negedge clk);
    ce = 1'b0;
    #1;
    n = 0;
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("busy mtlo done seen", 64'(done), 64'd1);
    check("busy mtlo lo kept product", 64'(lo), 64'd20);
    check("busy mtlo hi", 64'(hi), 64'd0);

    // Back-to-back: new DIVU issued in the done-pulse cycle
    run_op(F_DIVU, 32'd100, 32'd7, 1'b1, cyc, early, d_end);
    check("b2b stall_cycles", 64'(cyc), 64'(LAT));
    check("b2b done", 64'(d_end), 64'd1);
    check("b2b lo", 64'(lo), 64'd14);
    check("b2b hi", 64'(hi), 64'd2);

    // Flush mid-BUSY: HI/LO preserved, no done pulse
    mt_write(F_MTHI, 32'h0000_00AA);
    mt_write(F_MTLO, 32'h0000_00AA);
    @(negedge clk);
    ce = 1'b1; op = 6'h00; funct = F_MULT; rs = 32'd5; rt = 32'd4;
    @(negedge clk);
    ce = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1 check("flush stall before edge", 64'(stall), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush idle stall", 64'(stall), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush hi", 64'(hi), 64'h00AA);
    check("flush lo", 64'(lo), 64'h00AA);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done || stall) n++;
    end
    check("flush no later done", 64'(n), 64'd0);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    ce = 1'b1; op = 6'h00; funct = F_MULT; rs = 32'd5; rt = 32'd4;
    @(negedge clk);
    ce = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst mid stall", 64'(stall), 64'd0);
    check("rst mid hi", 64'(hi), 64'd0);
    check("rst mid lo", 64'(lo), 64'd0);
    check("rst mid done", 64'(done), 64'd0);
    check("rst mid valid", 64'(valid), 64'd0);
    check("rst mid value", 64'(value), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Recovery after reset
    run_op(F_MULT, 32'd6, 32'd7, 1'b0, cyc, early, d_end);
    check("post-rst stall_cycles", 64'(cyc), 64'(LAT));
    check("post-rst lo", 64'(lo), 64'd42);
    check("post-rst hi", 64'(hi), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
